// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and compare helper for the PWM output stage
package pwm_pkg;

  localparam int PWM_RES          = 8;
  localparam int NUM_CH           = 16;
  localparam int DEFAULT_PRESCALE = 13;
  localparam logic [PWM_RES-1:0] DUTY_FULL = 8'hFF;

  // Full-scale duty is forced high so 100 % never shows a one-count dip at cnt=255.
  function automatic logic pwm_level(input logic [PWM_RES-1:0] cnt,
                                     input logic [PWM_RES-1:0] duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - free-running divider emitting one tick every PRESCALE clocks
module pwm_prescaler #(
  parameter int PRESCALE = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  // With PRESCALE=1 the counter is stuck at 0 and tick is asserted every cycle.
  assign tick = (psc == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (tick) begin
      psc <= '0;
    end else begin
      psc <= psc + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// rtl/pwm_output_stage.sv - drives 16 chip outputs as low, high or a shared glitch-free PWM
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_CH-1:0]  out,
  output logic               period_start
);

  logic                tick;
  logic                wrap;
  logic                pwm;
  logic [PWM_RES-1:0]  cnt;
  logic [PWM_RES-1:0]  duty_shadow;
  logic [NUM_CH-1:0]   en_out;
  logic [NUM_CH-1:0]   en_pwm;
  logic [NUM_CH-1:0]   out_next;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap     = tick && (cnt == '1);
  assign pwm      = pwm_level(cnt, duty_shadow);
  assign out_next = en_out & (~en_pwm | {NUM_CH{pwm}});

  // Duty is only sampled on wrap so a mid-period write never produces a runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      duty_shadow  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= cnt + PWM_RES'(1);
      end
      if (wrap) begin
        duty_shadow <= pwm_duty_cycle;
      end
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule
